// File: rtl/ddr_ioctl_uploader_if.sv
// rtl/ddr_ioctl_uploader_if.sv - DDR host-port bundle shared with the DDR arbiter
interface ddr_if;
  logic        acquire;
  logic [31:0] addr;
  logic        read;
  logic        write;
  logic [7:0]  byteenable;
  logic [7:0]  burstcnt;
  logic [63:0] wdata;
  logic        busy;
  logic [63:0] rdata;
  logic        rdata_ready;

  modport to_host (
    output acquire, addr, read, write, byteenable, burstcnt, wdata,
    input  busy, rdata, rdata_ready
  );

  modport to_ddr (
    input  acquire, addr, read, write, byteenable, burstcnt, wdata,
    output busy, rdata, rdata_ready
  );
endinterface

// File: rtl/ddr_ioctl_uploader.sv
// rtl/ddr_ioctl_uploader.sv - ioctl upload of a DDR region, byte-serialized with a one-word prefetch
module ddr_ioctl_uploader #(
  parameter logic [31:0] DDR_BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0]  UPLOAD_INDEX  = 8'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  input  logic [24:0] length,
  ddr_if.to_host      ddr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_t;

  state_t      state_q, state_d;
  logic        upload_q, upload_d;
  logic [24:0] length_q, length_d;
  logic [63:0] cur_word_q, cur_word_d;
  logic [21:0] cur_tag_q, cur_tag_d;
  logic        cur_valid_q, cur_valid_d;
  logic [63:0] pre_word_q, pre_word_d;
  logic [21:0] pre_tag_q, pre_tag_d;
  logic        pre_valid_q, pre_valid_d;
  logic        pre_busy_q, pre_busy_d;
  logic        pf_pend_q, pf_pend_d;
  logic        dem_pend_q, dem_pend_d;
  logic [24:0] dem_addr_q, dem_addr_d;
  logic [21:0] fetch_tag_q, fetch_tag_d;
  logic        fetch_pre_q, fetch_pre_d;
  logic        discard_q, discard_d;
  logic        acquire_q, acquire_d;
  logic        read_q, read_d;
  logic [31:0] addr_q, addr_d;
  logic        wait_q, wait_d;
  logic [7:0]  din_q, din_d;

  logic        active, rise, fall, strobe;
  logic [21:0] a_tag, dem_tag;
  logic        a_oor, a_hit, a_pro, served, trig, miss_now, rd_done;

  function automatic logic [7:0] pick_byte(input logic [63:0] w, input logic [2:0] sel);
    return w[{sel, 3'b000} +: 8];
  endfunction

  // True when the word after tag still holds at least one in-range byte.
  function automatic logic next_in_range(input logic [21:0] tag, input logic [24:0] len);
    logic [22:0] nt;
    nt = {1'b0, tag} + 23'd1;
    return {nt, 3'b000} < {1'b0, len};
  endfunction

  assign active   = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
  assign rise     = ioctl_upload & ~upload_q;
  assign fall     = ~ioctl_upload & upload_q;
  assign strobe   = active & ioctl_rd & ~wait_q;
  assign a_tag    = ioctl_addr[24:3];
  assign dem_tag  = dem_addr_q[24:3];
  assign a_oor    = ioctl_addr >= length_q;
  assign a_hit    = cur_valid_q & (cur_tag_q == a_tag);
  assign a_pro    = pre_valid_q & (pre_tag_q == a_tag);
  assign served   = strobe & ~a_oor & (a_hit | a_pro);
  assign trig     = served & (ioctl_addr[2:0] == 3'd0) & next_in_range(a_tag, length_q)
                  & (a_pro | ~pre_valid_q) & ~pre_busy_q;
  assign miss_now = strobe & ~a_oor & ~a_hit & ~a_pro;
  assign rd_done  = (state_q == WAIT_RD) & ~read_q & ddr.rdata_ready;

  always_comb begin
    state_d     = state_q;
    upload_d    = ioctl_upload;
    length_d    = length_q;
    cur_word_d  = cur_word_q;
    cur_tag_d   = cur_tag_q;
    cur_valid_d = cur_valid_q;
    pre_word_d  = pre_word_q;
    pre_tag_d   = pre_tag_q;
    pre_valid_d = pre_valid_q;
    pre_busy_d  = pre_busy_q;
    pf_pend_d   = pf_pend_q;
    dem_pend_d  = dem_pend_q;
    dem_addr_d  = dem_addr_q;
    fetch_tag_d = fetch_tag_q;
    fetch_pre_d = fetch_pre_q;
    discard_d   = discard_q;
    acquire_d   = acquire_q;
    read_d      = read_q;
    addr_d      = addr_q;
    wait_d      = wait_q;
    din_d       = din_q;

    if (rise) length_d = length;

    if (strobe) begin
      if (a_oor) begin
        din_d = 8'hFF;
      end else if (a_hit) begin
        din_d = pick_byte(cur_word_q, ioctl_addr[2:0]);
      end else if (a_pro) begin
        din_d       = pick_byte(pre_word_q, ioctl_addr[2:0]);
        cur_word_d  = pre_word_q;
        cur_tag_d   = pre_tag_q;
        cur_valid_d = 1'b1;
        pre_valid_d = 1'b0;
      end else begin
        wait_d     = 1'b1;
        dem_pend_d = 1'b1;
        dem_addr_d = ioctl_addr;
      end
    end

    if (trig) begin
      pf_pend_d  = 1'b1;
      pre_busy_d = 1'b1;
      pre_tag_d  = a_tag + 22'd1;
    end

    case (state_q)
      IDLE: begin
        if (pf_pend_q) begin
          pf_pend_d   = 1'b0;
          fetch_tag_d = pre_tag_q;
          fetch_pre_d = 1'b1;
          discard_d   = 1'b0;
          acquire_d   = 1'b1;
          state_d     = REQ;
        end else if (dem_pend_q) begin
          // A prefetch may have landed in the same cycle the miss was taken.
          if (pre_valid_q && pre_tag_q == dem_tag) begin
            cur_word_d  = pre_word_q;
            cur_tag_d   = pre_tag_q;
            cur_valid_d = 1'b1;
            pre_valid_d = 1'b0;
            state_d     = RESP;
          end else begin
            fetch_tag_d = dem_tag;
            fetch_pre_d = 1'b0;
            discard_d   = 1'b0;
            acquire_d   = 1'b1;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (!ddr.busy) begin
          addr_d  = DDR_BASE_ADDR + {7'd0, fetch_tag_q, 3'b000};
          read_d  = 1'b1;
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (read_q && !ddr.busy) read_d = 1'b0;
        if (rd_done) begin
          if (fetch_pre_q) pre_busy_d = 1'b0;
          if (dem_pend_q) begin
            if (!discard_q && fetch_tag_q == dem_tag) begin
              cur_word_d  = ddr.rdata;
              cur_tag_d   = fetch_tag_q;
              cur_valid_d = 1'b1;
              acquire_d   = 1'b0;
              state_d     = RESP;
            end else begin
              // Wrong or stale word: drop it and chain the demand fetch.
              fetch_tag_d = dem_tag;
              fetch_pre_d = 1'b0;
              discard_d   = 1'b0;
              state_d     = REQ;
            end
          end else begin
            if (!discard_q && fetch_pre_q) begin
              pre_word_d  = ddr.rdata;
              pre_tag_d   = fetch_tag_q;
              pre_valid_d = 1'b1;
            end else if (!discard_q) begin
              cur_word_d  = ddr.rdata;
              cur_tag_d   = fetch_tag_q;
              cur_valid_d = 1'b1;
            end
            acquire_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      RESP: begin
        din_d      = pick_byte(cur_word_q, dem_addr_q[2:0]);
        wait_d     = 1'b0;
        dem_pend_d = 1'b0;
        state_d    = IDLE;
        if (dem_addr_q[2:0] == 3'd0 && next_in_range(cur_tag_q, length_q) &&
            !pre_valid_q && !pre_busy_q) begin
          pf_pend_d  = 1'b1;
          pre_busy_d = 1'b1;
          pre_tag_d  = cur_tag_q + 22'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // End of upload: forget everything, but let an issued read run to completion.
    if (fall) begin
      cur_valid_d = 1'b0;
      pre_valid_d = 1'b0;
      pre_busy_d  = 1'b0;
      pf_pend_d   = 1'b0;
      dem_pend_d  = 1'b0;
      wait_d      = 1'b0;
      if (state_q == REQ || (state_q == WAIT_RD && !rd_done)) begin
        discard_d = 1'b1;
      end else begin
        state_d   = IDLE;
        acquire_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      upload_q    <= 1'b0;
      length_q    <= '0;
      cur_word_q  <= '0;
      cur_tag_q   <= '0;
      cur_valid_q <= 1'b0;
      pre_word_q  <= '0;
      pre_tag_q   <= '0;
      pre_valid_q <= 1'b0;
      pre_busy_q  <= 1'b0;
      pf_pend_q   <= 1'b0;
      dem_pend_q  <= 1'b0;
      dem_addr_q  <= '0;
      fetch_tag_q <= '0;
      fetch_pre_q <= 1'b0;
      discard_q   <= 1'b0;
      acquire_q   <= 1'b0;
      read_q      <= 1'b0;
      addr_q      <= '0;
      wait_q      <= 1'b0;
      din_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      upload_q    <= upload_d;
      length_q    <= length_d;
      cur_word_q  <= cur_word_d;
      cur_tag_q   <= cur_tag_d;
      cur_valid_q <= cur_valid_d;
      pre_word_q  <= pre_word_d;
      pre_tag_q   <= pre_tag_d;
      pre_valid_q <= pre_valid_d;
      pre_busy_q  <= pre_busy_d;
      pf_pend_q   <= pf_pend_d;
      dem_pend_q  <= dem_pend_d;
      dem_addr_q  <= dem_addr_d;
      fetch_tag_q <= fetch_tag_d;
      fetch_pre_q <= fetch_pre_d;
      discard_q   <= discard_d;
      acquire_q   <= acquire_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      wait_q      <= wait_d;
      din_q       <= din_d;
    end
  end

  assign ioctl_din      = din_q;
  assign ioctl_wait     = wait_q | miss_now;
  assign ddr.acquire    = acquire_q;
  assign ddr.addr       = addr_q;
  assign ddr.read       = read_q;
  assign ddr.write      = 1'b0;
  assign ddr.byteenable = 8'hFF;
  assign ddr.burstcnt   = 8'd1;
  assign ddr.wdata      = 64'd0;

endmodule
